// File: rtl/alu_param_seq_if.sv
// alu_param_seq_if: command/operand and result bundle for alu_param_seq.
interface alu_param_seq_if #(parameter int W = 4);
  logic init;
  logic [1:0] opcode;
  logic [W-1:0] port_a, port_b;
  logic [2*W-1:0] result;
  logic busy, done, neg, div_zero;
  modport master (output init, opcode, port_a, port_b, input result, busy, done, neg, div_zero);
  modport slave (input init, opcode, port_a, port_b, output result, busy, done, neg, div_zero);
endinterface

// File: rtl/alu_param_seq.sv
// alu_param_seq: multi-cycle unsigned ALU (add/|sub|, shift-add multiply, restoring divide).
module alu_param_seq #(parameter int W = 4) (
  input logic G_CLOCK_50,
  input logic V_BT,
  alu_param_seq_if.slave bus
);
  localparam int W2 = 2 * W;
  localparam int CW = $clog2(W);
  typedef enum logic [2:0] {IDLE, ADDSUB, MULT, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [W-1:0] b_q, b_d;
  logic [W2-1:0] wk_q, wk_d, acc_q, acc_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, dz_q, dz_d;
  logic [W:0] sh;
  logic lt, last;
  // wk holds A in its low half; MULT shifts it as the multiplicand, DIV uses it as {remainder, quotient}
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    b_d = b_q;
    wk_d = wk_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    neg_d = neg_q;
    dz_d = dz_q;
    sh = {wk_q[W2-1:W], wk_q[W-1]};
    lt = sh < {1'b0, b_q};
    last = cnt_q == CW'(W - 1);
    case (state_q)
      IDLE: if (bus.init) begin
        op_d = bus.opcode;
        b_d = bus.port_b;
        wk_d = W2'(bus.port_a);
        acc_d = '0;
        cnt_d = '0;
        state_d = bus.opcode[1] ? (bus.opcode[0] ? DIV : MULT) : ADDSUB;
      end
      ADDSUB: begin
        res_d = op_q[0] ? W2'(wk_q[W-1:0] < b_q ? b_q - wk_q[W-1:0] : wk_q[W-1:0] - b_q)
                        : W2'({1'b0, wk_q[W-1:0]} + {1'b0, b_q});
        neg_d = op_q[0] & (wk_q[W-1:0] < b_q);
        dz_d = 1'b0;
        state_d = DONE;
      end
      MULT: begin
        acc_d = acc_q + (b_q[0] ? wk_q : '0);
        wk_d = wk_q << 1;
        b_d = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          res_d = acc_d;
          neg_d = 1'b0;
          dz_d = 1'b0;
          state_d = DONE;
        end
      end
      DIV: if (b_q == '0) begin
        res_d = {wk_q[W-1:0], {W{1'b1}}};
        neg_d = 1'b0;
        dz_d = 1'b1;
        state_d = DONE;
      end else begin
        wk_d = {lt ? sh[W-1:0] : W'(sh - {1'b0, b_q}), wk_q[W-2:0], ~lt};
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          res_d = wk_d;
          neg_d = 1'b0;
          dz_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge G_CLOCK_50 or posedge V_BT) begin
    if (V_BT) begin
      state_q <= IDLE;
      op_q <= '0;
      b_q <= '0;
      wk_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      neg_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      b_q <= b_d;
      wk_q <= wk_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      neg_q <= neg_d;
      dz_q <= dz_d;
    end
  end
  assign bus.result = res_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.neg = neg_q;
  assign bus.div_zero = dz_q;
endmodule

// File: doc/alu_param_seq.md
ALU_PARAM_SEQ -- requirements
Module: alu_param_seq

Interface
- REQ-001 Parameter W, default 4: operand width in bits, legal range 2..16.
- REQ-002 G_CLOCK_50  input  1  sole clock; all state updates on its rising edge.
- REQ-003 V_BT  input  1  reset, asynchronous, active-high.
- REQ-004 init  input  1  start request, level-sampled in IDLE.
- REQ-005 opcode  input  2  operation select: 00 add, 01 sub, 10 mult, 11 div.
- REQ-006 port_a  input  W  operand A, unsigned.
- REQ-007 port_b  input  W  operand B, unsigned.
- REQ-008 result  output  2W  registered result.
- REQ-009 busy  output  1  high from the accepting edge until the edge that leaves DONE.
- REQ-010 done  output  1  one-cycle pulse marking result valid.
- REQ-011 neg  output  1  sub result negative; 0 for all other opcodes.
- REQ-012 div_zero  output  1  division by zero occurred; 0 for all other opcodes.

Function
- REQ-013 FSM states SHALL be IDLE, ADDSUB, MULT, DIV, DONE.
- REQ-014 In IDLE with init=1, the edge SHALL latch port_a, port_b and opcode, and enter ADDSUB (00/01), MULT (10) or DIV (11); busy=1 from that edge.
- REQ-015 Inputs changing while busy=1 SHALL not affect the operation in progress; init while busy SHALL be ignored, not queued.
- REQ-016 ADDSUB SHALL take one cycle, then enter DONE.
- REQ-017 Add SHALL give result = zero-extended A+B (W+1 significant bits, no overflow loss), neg=0.
- REQ-018 Sub SHALL give result = |A-B| zero-extended; neg=1 iff A<B.
- REQ-019 MULT SHALL be shift-add over exactly W cycles with an internal iteration counter, then DONE; result = A*B in 2W bits.
- REQ-020 DIV SHALL be restoring division over exactly W cycles, then DONE; result[W-1:0] = quotient, result[2W-1:W] = remainder.
- REQ-021 DIV with B=0 SHALL skip iteration, enter DONE after one cycle, and give quotient all ones, remainder = A, div_zero=1.
- REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE; busy=0 in the IDLE cycle.
- REQ-023 Latency (accepting edge to done=1) SHALL be 2 cycles for add/sub and div-by-zero, and W+1 cycles for mult and div.
- REQ-024 result, neg and div_zero SHALL update only on the edge entering DONE and hold until the next entry to DONE; intermediate partial values SHALL never appear on result.
- REQ-025 With init held high, a new operation SHALL be accepted on the first IDLE edge after DONE, giving back-to-back throughput of one operation per latency+1 cycles.
- REQ-026 Undefined opcode values cannot occur (2-bit fully decoded); FSM encoding SHALL recover to IDLE from any unused state code.

Reset
- REQ-027 V_BT=1 SHALL immediately, independent of the clock, force state IDLE, result=0, busy=0, done=0, neg=0, div_zero=0, and clear counter and working registers.
- REQ-028 Reset asserted mid-operation SHALL abort it without a done pulse; after release the block SHALL wait for a fresh init.
- REQ-029 init high during reset release SHALL be accepted on the first rising edge with V_BT=0.

Verification (W=4)
- REQ-030 A=7, B=5, op=00, init 1 cycle -> done 2 cycles later, result=12, neg=0.
- REQ-031 A=3, B=6, op=01 -> result=3, neg=1; A=6, B=3 -> result=3, neg=0.
- REQ-032 A=15, B=15, op=10 -> busy for 5 cycles, done at cycle 5, result=225; input changes during busy have no effect.
- REQ-033 A=13, B=4, op=11 -> result[3:0]=3, result[7:4]=1, done at cycle 5; A=9, B=0 -> quotient=15, remainder=9, div_zero=1, done at cycle 2.
- REQ-034 Start mult A=5, B=6; assert V_BT at cycle 2 -> outputs 0 immediately, no done; after release, new add 2+2 -> result=4.
- REQ-035 init held high with alternating opcodes -> each operation accepted exactly once per DONE->IDLE cycle, done is a single-cycle pulse each time.
